// File: rtl/spi_pkg.sv
// Shared command-field constants, default status address and FSM state encoding
// for the SPI register bank.
package spi_pkg;

    localparam int CMD_WR_BIT = 7;
    localparam int ADDR_MSB   = 6;

    localparam logic [6:0] DEF_STATUS_ADDR = 7'h7F;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_WDATA  = 2'd1,
        WAIT_RDUMMY = 2'd2
    } state_t;

endpackage

// File: rtl/spi_timeout_ctr.sv
// Saturating idle-cycle counter; done is raised once the count reaches TIMEOUT_CYC.
module spi_timeout_ctr #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

    logic [CW-1:0] count;

    assign done = (count == LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !done) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_reg_bank.sv
// Two-frame SPI register access: a command byte (R/W + address) followed by a
// data frame that either writes a config register or shifts out read data.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int         NUM_REGS    = 16,
    parameter logic [7:0] RST_VAL     = 8'h00,
    parameter int         TIMEOUT_CYC = 4096,
    parameter logic [6:0] STATUS_ADDR = DEF_STATUS_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            spi_out,
    input  logic                  spi_out_rdy,
    input  logic                  cs_sync,
    input  logic [7:0]            status_in,
    output logic [7:0]            spi_data,
    output logic [8*NUM_REGS-1:0] cfg_regs,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr,
    output logic                  timeout_err
);

    state_t                  state;
    logic [6:0]              addr;
    logic [8*NUM_REGS-1:0]   cfg_q;
    logic [6:0]              cmd_addr;
    logic [7:0]              rd_val;
    logic                    addr_hit;
    logic                    timer_clear;
    logic                    timer_done;

    assign cfg_regs = cfg_q;
    assign cmd_addr = spi_out[ADDR_MSB:0];

    // Mapped registers take precedence over the status address should they overlap.
    always_comb begin
        rd_val = 8'h00;
        if (cmd_addr == STATUS_ADDR) begin
            rd_val = status_in;
        end
        for (int k = 0; k < NUM_REGS; k++) begin
            if (cmd_addr == 7'(k)) begin
                rd_val = cfg_q[8*k +: 8];
            end
        end
    end

    assign addr_hit = (int'(addr) < NUM_REGS);

    // The timer only runs while waiting for the second frame and restarts on any exit.
    assign timer_clear = (state == IDLE) || spi_out_rdy || timer_done;

    spi_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (cs_sync),
        .done   (timer_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            addr        <= '0;
            cfg_q       <= {NUM_REGS{RST_VAL}};
            spi_data    <= 8'h00;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            timeout_err <= 1'b0;
        end else begin
            wr_strobe   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (spi_out_rdy) begin
                        addr <= cmd_addr;
                        if (spi_out[CMD_WR_BIT]) begin
                            state    <= WAIT_WDATA;
                            spi_data <= 8'h00;
                        end else begin
                            state    <= WAIT_RDUMMY;
                            spi_data <= rd_val;
                        end
                    end
                end
                WAIT_WDATA: begin
                    if (spi_out_rdy) begin
                        if (addr_hit) begin
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (addr == 7'(k)) begin
                                    cfg_q[8*k +: 8] <= spi_out;
                                end
                            end
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr;
                        end
                        spi_data <= 8'h00;
                        state    <= IDLE;
                    end else if (timer_done) begin
                        timeout_err <= 1'b1;
                        spi_data    <= 8'h00;
                        state       <= IDLE;
                    end
                end
                WAIT_RDUMMY: begin
                    if (spi_out_rdy) begin
                        spi_data <= 8'h00;
                        state    <= IDLE;
                    end else if (timer_done) begin
                        timeout_err <= 1'b1;
                        spi_data    <= 8'h00;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scenario-driven bench for spi_reg_bank with a bench-side register model and a
// queue of expected spi_data values.
module tb_spi_reg_bank;

    localparam int         NUM_REGS    = 16;
    localparam logic [7:0] RST_VAL     = 8'hA5;
    localparam int         TIMEOUT_CYC = 8;

    logic                  clk;
    logic                  rst;
    logic [7:0]            spi_out;
    logic                  spi_out_rdy;
    logic                  cs_sync;
    logic [7:0]            status_in;
    logic [7:0]            spi_data;
    logic [8*NUM_REGS-1:0] cfg_regs;
    logic                  wr_strobe;
    logic [6:0]            wr_addr;
    logic                  timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_regs [NUM_REGS];
    logic [6:0] exp_wr_addr;
    logic [7:0] exp_q [$];
    logic [7:0] e;

    spi_reg_bank #(
        .NUM_REGS    (NUM_REGS),
        .RST_VAL     (RST_VAL),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_out     (spi_out),
        .spi_out_rdy (spi_out_rdy),
        .cs_sync     (cs_sync),
        .status_in   (status_in),
        .spi_data    (spi_data),
        .cfg_regs    (cfg_regs),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8*NUM_REGS-1:0] model_flat();
        logic [8*NUM_REGS-1:0] f;
        for (int k = 0; k < NUM_REGS; k++) f[8*k +: 8] = exp_regs[k];
        return f;
    endfunction

    // Called at a negedge; the byte is sampled on the next posedge and the task
    // returns at the following negedge, when the registered outputs are settled.
    task automatic send_byte(input logic [7:0] b);
        spi_out     = b;
        spi_out_rdy = 1'b1;
        @(negedge clk);
        spi_out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = RST_VAL;
        exp_wr_addr = 7'd0;
        n_checks++;
        if (spi_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_spi_data got %h want 00", spi_data); end
        n_checks++;
        if (cfg_regs !== model_flat()) begin n_fail++; $display("[TB] FAIL reset_cfg got %h want %h", cfg_regs, model_flat()); end
        n_checks++;
        if (wr_strobe !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr_strobe got %b want 0", wr_strobe); end
        n_checks++;
        if (wr_addr !== 7'd0) begin n_fail++; $display("[TB] FAIL reset_wr_addr got %h want 00", wr_addr); end
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_timeout_err got %b want 0", timeout_err); end
    endtask

    task automatic test_write_read();
        exp_q.push_back(8'h00);
        send_byte(8'h83);
        e = exp_q.pop_front();
        n_checks++;
        if (spi_data !== e) begin n_fail++; $display("[TB] FAIL wcmd_spi_data got %h want %h", spi_data, e); end
        exp_regs[3] = 8'h5A;
        exp_wr_addr = 7'd3;
        exp_q.push_back(8'h00);
        send_byte(8'h5A);
        e = exp_q.pop_front();
        n_checks++;
        if (wr_strobe !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_strobe_pulse got %b want 1", wr_strobe); end
        n_checks++;
        if (wr_addr !== exp_wr_addr) begin n_fail++; $display("[TB] FAIL wr_addr got %h want %h", wr_addr, exp_wr_addr); end
        n_checks++;
        if (cfg_regs !== model_flat()) begin n_fail++; $display("[TB] FAIL write_reg3 got %h want %h", cfg_regs, model_flat()); end
        n_checks++;
        if (spi_data !== e) begin n_fail++; $display("[TB] FAIL wdata_spi_data got %h want %h", spi_data, e); end
        @(negedge clk);
        n_checks++;
        if (wr_strobe !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_strobe_one_cycle got %b want 0", wr_strobe); end
        exp_q.push_back(exp_regs[3]);
        send_byte(8'h03);
        e = exp_q.pop_front();
        n_checks++;
        if (spi_data !== e) begin n_fail++; $display("[TB] FAIL read_reg3 got %h want %h", spi_data, e); end
        exp_q.push_back(8'h00);
        send_byte(8'hFF);
        e = exp_q.pop_front();
        n_checks++;
        if (spi_data !== e) begin n_fail++; $display("[TB] FAIL read_dummy_spi_data got %h want %h", spi_data, e); end
        n_checks++;
        if (cfg_regs !== model_flat() || wr_strobe !== 1'b0) begin
            n_fail++; $display("[TB] FAIL read_dummy_no_write got %h/%b want %h/0", cfg_regs, wr_strobe, model_flat());
        end
    endtask

    task automatic test_status_unmapped();
        status_in = 8'hC3;
        exp_q.push_back(8'hC3);
        send_byte(8'h7F);
        status_in = 8'h3C;
        e = exp_q.pop_front();
        n_checks++;
        if (spi_data !== e) begin n_fail++; $display("[TB] FAIL status_read got %h want %h", spi_data, e); end
        @(negedge clk);
        n_checks++;
        if (spi_data !== 8'hC3) begin n_fail++; $display("[TB] FAIL status_held got %h want c3", spi_data); end
        exp_q.push_back(8'h00);
        send_byte(8'h00);
        e = exp_q.pop_front();
        n_checks++;
        if (spi_data !== e) begin n_fail++; $display("[TB] FAIL status_dummy got %h want %h", spi_data, e); end
        send_byte(8'hFF);
        send_byte(8'h11);
        n_checks++;
        if (wr_strobe !== 1'b0) begin n_fail++; $display("[TB] FAIL status_write_strobe got %b want 0", wr_strobe); end
        n_checks++;
        if (cfg_regs !== model_flat() || wr_addr !== exp_wr_addr) begin
            n_fail++; $display("[TB] FAIL status_write_dropped got %h/%h want %h/%h", cfg_regs, wr_addr, model_flat(), exp_wr_addr);
        end
        exp_q.push_back(8'h00);
        send_byte(8'h20);
        e = exp_q.pop_front();
        n_checks++;
        if (spi_data !== e) begin n_fail++; $display("[TB] FAIL unmapped_read got %h want %h", spi_data, e); end
        send_byte(8'h00);
        send_byte(8'h90);
        send_byte(8'h77);
        n_checks++;
        if (wr_strobe !== 1'b0 || cfg_regs !== model_flat()) begin
            n_fail++; $display("[TB] FAIL unmapped_write got %b/%h want 0/%h", wr_strobe, cfg_regs, model_flat());
        end
    endtask

    task automatic test_timeout();
        int seen_at;
        seen_at = 0;
        cs_sync = 1'b0;
        send_byte(8'h81);
        cs_sync = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin
                seen_at = i;
                break;
            end
        end
        n_checks++;
        if (seen_at != TIMEOUT_CYC + 1) begin
            n_fail++; $display("[TB] FAIL timeout_cycle got %0d want %0d", seen_at, TIMEOUT_CYC + 1);
        end
        @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_one_cycle got %b want 0", timeout_err); end
        cs_sync = 1'b0;
        exp_q.push_back(8'h00);
        send_byte(8'h22);
        e = exp_q.pop_front();
        n_checks++;
        if (wr_strobe !== 1'b0 || cfg_regs !== model_flat()) begin
            n_fail++; $display("[TB] FAIL timeout_then_cmd got %b/%h want 0/%h", wr_strobe, cfg_regs, model_flat());
        end
        n_checks++;
        if (spi_data !== e) begin n_fail++; $display("[TB] FAIL timeout_read22 got %h want %h", spi_data, e); end
        send_byte(8'h00);
    endtask

    task automatic test_timer_hold();
        int err_seen;
        err_seen = 0;
        cs_sync = 1'b0;
        send_byte(8'h81);
        repeat (100) begin
            @(negedge clk);
            if (timeout_err !== 1'b0) err_seen++;
        end
        exp_regs[1] = 8'h44;
        exp_wr_addr = 7'd1;
        send_byte(8'h44);
        if (timeout_err !== 1'b0) err_seen++;
        n_checks++;
        if (err_seen != 0) begin n_fail++; $display("[TB] FAIL hold_no_timeout got %0d pulses want 0", err_seen); end
        n_checks++;
        if (wr_strobe !== 1'b1 || cfg_regs !== model_flat()) begin
            n_fail++; $display("[TB] FAIL hold_write got %b/%h want 1/%h", wr_strobe, cfg_regs, model_flat());
        end
    endtask

    task automatic test_coincidence();
        cs_sync = 1'b0;
        send_byte(8'h82);
        cs_sync = 1'b1;
        repeat (TIMEOUT_CYC) @(negedge clk);
        exp_regs[2] = 8'h6B;
        exp_wr_addr = 7'd2;
        send_byte(8'h6B);
        n_checks++;
        if (wr_strobe !== 1'b1 || wr_addr !== exp_wr_addr || cfg_regs !== model_flat()) begin
            n_fail++; $display("[TB] FAIL coincide_write got %b/%h/%h want 1/%h/%h", wr_strobe, wr_addr, cfg_regs, exp_wr_addr, model_flat());
        end
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL coincide_timeout got %b want 0", timeout_err); end
        @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL coincide_late_timeout got %b want 0", timeout_err); end
        cs_sync = 1'b0;
    endtask

    task automatic test_reset_mid();
        send_byte(8'h85);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = RST_VAL;
        exp_wr_addr = 7'd0;
        n_checks++;
        if (cfg_regs !== model_flat() || wr_addr !== 7'd0) begin
            n_fail++; $display("[TB] FAIL midreset_state got %h/%h want %h/00", cfg_regs, wr_addr, model_flat());
        end
        exp_q.push_back(8'h00);
        send_byte(8'h99);
        e = exp_q.pop_front();
        n_checks++;
        if (wr_strobe !== 1'b0 || cfg_regs !== model_flat() || spi_data !== e) begin
            n_fail++; $display("[TB] FAIL midreset_99_as_cmd got %b/%h/%h want 0/%h/%h", wr_strobe, cfg_regs, spi_data, model_flat(), e);
        end
        send_byte(8'h12);
        n_checks++;
        if (wr_strobe !== 1'b0 || cfg_regs !== model_flat()) begin
            n_fail++; $display("[TB] FAIL midreset_unmapped_write got %b/%h want 0/%h", wr_strobe, cfg_regs, model_flat());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int k = 0; k < NUM_REGS; k++) begin
            d = 8'($urandom_range(0, 255));
            exp_regs[k] = d;
            exp_wr_addr = 7'(k);
            send_byte({1'b1, 7'(k)});
            send_byte(d);
            n_checks++;
            if (wr_strobe !== 1'b1 || wr_addr !== exp_wr_addr || cfg_regs !== model_flat()) begin
                n_fail++; $display("[TB] FAIL b2b_write%0d got %b/%h/%h want 1/%h/%h", k, wr_strobe, wr_addr, cfg_regs, exp_wr_addr, model_flat());
            end
        end
        for (int k = NUM_REGS - 1; k >= 0; k--) begin
            exp_q.push_back(exp_regs[k]);
            send_byte({1'b0, 7'(k)});
            e = exp_q.pop_front();
            n_checks++;
            if (spi_data !== e) begin n_fail++; $display("[TB] FAIL b2b_read%0d got %h want %h", k, spi_data, e); end
            send_byte(8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        rst         = 1'b0;
        spi_out     = 8'h00;
        spi_out_rdy = 1'b0;
        cs_sync     = 1'b0;
        status_in   = 8'h00;
        test_reset();
        test_write_read();
        test_status_unmapped();
        test_timeout();
        test_timer_hold();
        test_coincidence();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Downstream consumer of the SPI slave byte interface; turns single-byte SPI frames into a two-frame register-access protocol.
- The first frame carries a command byte; the second frame carries write data or returns read data.
- Holds NUM_REGS 8-bit configuration registers for the digital block.
- Drives the slave's parallel load input so that read data is shifted out on the second frame.

Parameters:
- NUM_REGS, 16, number of writable config registers (addresses 0..NUM_REGS-1); legal range 1..127.
- RST_VAL, 8'h00, reset value of every config register.
- TIMEOUT_CYC, 4096, clk cycles of bus idle (cs_sync=1) allowed between the command frame and the data frame.
- STATUS_ADDR, 7'h7F, read-only address that returns status_in.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- spi_out  in  8  byte received by the SPI slave (its OUT).
- spi_out_rdy  in  1  one-cycle pulse: spi_out is valid (end of frame).
- cs_sync  in  1  synchronized chip select from the slave; 1 = bus idle.
- status_in  in  8  live status byte, readable at STATUS_ADDR.
- spi_data  out  8  byte the slave loads at the next frame start (its DATA).
- cfg_regs  out  8*NUM_REGS  flattened registers; reg k occupies bits [8k+7:8k].
- wr_strobe  out  1  one-cycle pulse when a config register is written.
- wr_addr  out  7  address of the last write; held until the next write.
- timeout_err  out  1  one-cycle pulse when a pending access is abandoned.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, all cfg regs=RST_VAL, spi_data=8'h00, wr_strobe=0, wr_addr=0, timeout_err=0, timer=0.
  - A reset mid-access discards the pending access.
- Command byte format: bit7 = 1 write / 0 read; bits[6:0] = address.
- All outputs are registered. Every action happens on the first clk edge on which spi_out_rdy=1 is sampled (1-cycle latency).
- State IDLE:
  - On rdy, latch addr=spi_out[6:0] and timer=0.
  - If spi_out[7]=1: go to WAIT_WDATA; spi_data<=8'h00.
  - If spi_out[7]=0: go to WAIT_RDUMMY; spi_data<=read value.
  - Read value: reg[addr] if addr<NUM_REGS; status_in if addr==STATUS_ADDR; otherwise 8'h00.
  - status_in is sampled once, at command decode, not at frame start.
- State WAIT_WDATA, on rdy:
  - If addr<NUM_REGS: reg[addr]<=spi_out, wr_strobe=1, wr_addr<=addr.
  - Writes to STATUS_ADDR or to unmapped addresses are dropped silently (no strobe).
  - In all cases: spi_data<=8'h00, go to IDLE.
- State WAIT_RDUMMY, on rdy:
  - The received byte is ignored; spi_data<=8'h00; go to IDLE.
- Timer (WAIT states only):
  - Increments each cycle while cs_sync=1; holds while cs_sync=0, so an in-progress frame never times out. Saturates at TIMEOUT_CYC.
  - Cleared on leaving a WAIT state.
  - When timer==TIMEOUT_CYC and there is no rdy that cycle: go to IDLE, timeout_err pulses 1 cycle, spi_data<=8'h00.
  - If rdy and timeout coincide, rdy wins: the access completes normally and there is no timeout_err.
- spi_data changes only on a rdy or timeout edge. The slave cannot sample it mid-frame because it loads only at the SS falling edge.
- Timer width: $clog2(TIMEOUT_CYC+1) bits.
- A register write is visible on cfg_regs in the same cycle that wr_strobe=1.

Decomposition:
- Shared package spi_pkg:
  - command field constants: CMD_WR_BIT=7, ADDR_MSB=6.
  - state encoding: IDLE=2'd0, WAIT_WDATA=2'd1, WAIT_RDUMMY=2'd2.
  - default STATUS_ADDR.
- One natural sub-module, spi_timeout_ctr: clear / enable / saturating counter, with a done flag at TIMEOUT_CYC.
- Register array and FSM stay in spi_reg_bank.
- A top-level spi_if instance wires SPI_slave OUT/SPI_OUT_RDY/CS_sync/DATA to this block.

Test Plan:
- Write then read: rdy 8'h83, then rdy 8'h5A → reg3=8'h5A, wr_strobe 1 cycle, wr_addr=3. Then rdy 8'h03 → spi_data=8'h5A next cycle; rdy 8'hFF → spi_data=8'h00, reg3 unchanged.
- Status/unmapped: status_in=8'hC3. Cmd 8'h7F → spi_data=8'hC3. Cmd 8'hFF then data 8'h11 → no wr_strobe, regs unchanged. Cmd 8'h20 (NUM_REGS=16) → spi_data=8'h00.
- Timeout (TIMEOUT_CYC=8): cmd 8'h81, then hold cs_sync=1 for 8 cycles → timeout_err pulse, state IDLE. The next rdy 8'h22 is treated as a command (a read of addr 0x22), not a write.
- Timer hold: cmd 8'h81, cs_sync=0 for 100 cycles, then rdy 8'h44 → reg1=8'h44, no timeout_err.
- Coincidence: rdy arrives on the exact cycle timer==TIMEOUT_CYC → write completes, timeout_err stays 0.
- Reset mid-access: cmd 8'h85, rst=0 for 1 cycle, then rdy 8'h99 → reg5=RST_VAL; 8'h99 is decoded as a write command to addr 0x19.
